radix4_mul_arbiter: RTL
=======================

// Module: radix4_mul_arbiter
// PURPOSE
//  Shares one radix-4 Booth multiplier (start/a_in/b_in -> result/done) among NREQ requesters.
//  Round-robin arbiter plus sequencing FSM: accepts one operand pair, pulses the multiplier's
//  start, waits for done, returns the product tagged to the winning requester.
//  Sits between client blocks and the single multiplier instance; the multiplier is external.
// PARAMETERS
//  NREQ     4   number of requesters (2..8)
//  W        4   operand width; product width is 2*W
//  TIMEOUT  16  WAIT-state cycle limit (used only when MUL_ARB_TIMEOUT_EN is defined)
// PORTS
//  clk         in   1         clock, all logic on rising edge
//  rst_n       in   1         asynchronous active-low reset
//  req_valid   in   NREQ      per-requester request valid
//  req_ready   out  NREQ      one-hot accept; pulses 1 cycle for the granted requester
//  req_a       in   NREQ*W    operand A, requester i at [i*W +: W]
//  req_b       in   NREQ*W    operand B, same packing
//  rsp_valid   out  NREQ      one-hot response valid, held until rsp_ready
//  rsp_result  out  2*W       product for the requester flagged in rsp_valid
//  rsp_err     out  1         timeout flag qualifying rsp_valid (constant 0 without macro)
//  rsp_ready   in   1         response consumed
//  mul_start   out  1         start pulse to multiplier
//  mul_a       out  W         operand A to multiplier, held stable ISSUE..WAIT
//  mul_b       out  W         operand B to multiplier, held stable ISSUE..WAIT
//  mul_result  in   2*W       multiplier product
//  mul_done    in   1         multiplier done (may be level/sticky)
// BEHAVIOUR
//  - Reset (rst_n=0, async): state=IDLE, rr pointer=0, all outputs 0; takes effect mid-operation,
//    in-flight request discarded, no response issued.
//  - FSM: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
//  - IDLE: if any req_valid, grant = first valid at/after rr pointer (wrapping NREQ-1 -> 0);
//    req_ready[grant]=1 this cycle (combinational), operands registered, next = ISSUE.
//    Pointer <= grant+1 mod NREQ. No valid -> stay IDLE, req_ready=0.
//  - ISSUE: mul_start=1 for exactly one cycle; next = WAIT; done-armed flag cleared.
//  - WAIT: mul_start=0. Done-armed sets on first cycle mul_done=0. With armed=1 and mul_done=1,
//    capture mul_result into rsp_result, next = RESP. Stale high done from previous op ignored.
//  - RESP: rsp_valid[grant]=1, rsp_result/rsp_err stable; on rsp_ready=1 -> IDLE (outputs clear
//    next cycle). Minimum turnaround accept-to-next-accept: 4 cycles + multiplier latency.
//  - Only one operation in flight; req_ready is 0 in all states except IDLE.
//  - req_valid dropping while not granted: no effect, no state kept per requester.
//  - Simultaneous rsp_ready and new req_valid: new request accepted in the following IDLE cycle.
//  - Products passed through unmodified; arbiter performs no arithmetic beyond pointer mod NREQ.
// CONFIGURATION
//  MUL_ARB_TIMEOUT_EN defined: WAIT counter increments each cycle; at TIMEOUT cycles without
//    armed done -> RESP with rsp_result=0, rsp_err=1; counter cleared in ISSUE.
//  Not defined: no counter, WAIT waits indefinitely, rsp_err tied 0 (port kept).
// STRUCTURE
//  Package radix4_mul_pkg: state enum (IDLE, ISSUE, WAIT, RESP), state width localparam,
//    product-width helper constant.
//  Sub-module rr_arbiter: NREQ-wide round-robin priority select (req, pointer -> one-hot grant,
//    grant index); FSM, operand registers and timeout stay in radix4_mul_arbiter.
// TESTING (bench uses behavioural multiplier model, 3-cycle latency, done held high until next start)
//  1 Single req0 A=4'b1101 B=4'b1011 -> one mul_start pulse, rsp_valid=4'b0001, rsp_result=8'h0F.
//  2 All four valid same cycle, continuous -> grants in order 0,1,2,3,0; each rsp tagged correctly.
//  3 rr pointer=2, req0 and req3 valid -> req3 granted first, then req0.
//  4 rsp_ready held 0 for 10 cycles -> rsp_valid/rsp_result stable, no req_ready pulse meanwhile.
//  5 rst_n low during WAIT -> all outputs 0 immediately, no response, next request served normally.
//  6 MUL_ARB_TIMEOUT_EN, model never asserts done -> RESP after 16 WAIT cycles, rsp_err=1, result 0.

Source files
------------

// File: rtl/radix4_mul_pkg.sv
// rtl/radix4_mul_pkg.sv - shared types and constants for the multiplier arbiter
// Optional timeout feature: MUL_ARB_TIMEOUT_EN (see radix4_mul_arbiter).
package radix4_mul_pkg;

    localparam int STATE_W     = 2;
    localparam int PROD_FACTOR = 2;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    function automatic int prod_width(input int w);
        return PROD_FACTOR * w;
    endfunction

endpackage

// File: rtl/radix4_mul_arbiter_rr_arbiter.sv
// rtl/radix4_mul_arbiter_rr_arbiter.sv - round-robin priority select
// Picks the first asserted request at or after ptr, wrapping past NREQ-1.
module rr_arbiter
    import radix4_mul_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDXW-1:0] ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDXW-1:0] grant_idx,
    output logic            any
);

    always_comb begin
        int j;
        j         = 0;
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            j = (int'(ptr) + i) % NREQ;
            if (!any && req[j]) begin
                any       = 1'b1;
                grant[j]  = 1'b1;
                grant_idx = IDXW'(j);
            end
        end
    end

endmodule

// File: rtl/radix4_mul_arbiter.sv
// rtl/radix4_mul_arbiter.sv - shares one external Booth multiplier among NREQ requesters
// Define MUL_ARB_TIMEOUT_EN to bound the WAIT state by TIMEOUT cycles and report rsp_err.
module radix4_mul_arbiter
    import radix4_mul_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int W       = 4,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    output logic [NREQ-1:0]   rsp_valid,
    output logic [2*W-1:0]    rsp_result,
    output logic              rsp_err,
    input  logic              rsp_ready,
    output logic              mul_start,
    output logic [W-1:0]      mul_a,
    output logic [W-1:0]      mul_b,
    input  logic [2*W-1:0]    mul_result,
    input  logic              mul_done
);

    localparam int IDXW = $clog2(NREQ);
    localparam int PW   = prod_width(W);

    state_t            state_q, state_d;
    logic [IDXW-1:0]   ptr_q, ptr_d;
    logic [NREQ-1:0]   grant_q, grant_d;
    logic [W-1:0]      op_a_q, op_a_d;
    logic [W-1:0]      op_b_q, op_b_d;
    logic              armed_q, armed_d;
    logic [PW-1:0]     res_q, res_d;

    logic [NREQ-1:0]   arb_grant;
    logic [IDXW-1:0]   arb_idx;
    logic              arb_any;

`ifdef MUL_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              err_q, err_d;
`endif

    rr_arbiter #(.NREQ(NREQ), .IDXW(IDXW)) u_rr_arbiter (
        .req       (req_valid),
        .ptr       (ptr_q),
        .grant     (arb_grant),
        .grant_idx (arb_idx),
        .any       (arb_any)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        armed_d = armed_q;
        res_d   = res_q;
`ifdef MUL_ARB_TIMEOUT_EN
        cnt_d   = cnt_q;
        err_d   = err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (arb_any) begin
                    state_d = S_ISSUE;
                    grant_d = arb_grant;
                    op_a_d  = req_a[arb_idx*W +: W];
                    op_b_d  = req_b[arb_idx*W +: W];
                    ptr_d   = (arb_idx == IDXW'(NREQ - 1)) ? '0 : arb_idx + 1'b1;
                end
            end
            S_ISSUE: begin
                armed_d = 1'b0;
                state_d = S_WAIT;
`ifdef MUL_ARB_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            S_WAIT: begin
                // done only counts once it has been seen low after our start
                if (!mul_done) begin
                    armed_d = 1'b1;
                end
                if (armed_q && mul_done) begin
                    res_d   = mul_result;
                    state_d = S_RESP;
`ifdef MUL_ARB_TIMEOUT_EN
                    err_d   = 1'b0;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    res_d   = '0;
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
`endif
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            grant_q <= '0;
            op_a_q  <= '0;
            op_b_q  <= '0;
            armed_q <= 1'b0;
            res_q   <= '0;
`ifdef MUL_ARB_TIMEOUT_EN
            cnt_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            armed_q <= armed_d;
            res_q   <= res_d;
`ifdef MUL_ARB_TIMEOUT_EN
            cnt_q   <= cnt_d;
            err_q   <= err_d;
`endif
        end
    end

    // rst_n gates the combinational accept so nothing is granted while held in reset
    assign req_ready  = (state_q == S_IDLE && rst_n) ? arb_grant : '0;
    assign mul_start  = (state_q == S_ISSUE);
    assign mul_a      = op_a_q;
    assign mul_b      = op_b_q;
    assign rsp_valid  = (state_q == S_RESP) ? grant_q : '0;
    assign rsp_result = (state_q == S_RESP) ? res_q : '0;
`ifdef MUL_ARB_TIMEOUT_EN
    assign rsp_err    = (state_q == S_RESP) & err_q;
`else
    assign rsp_err    = 1'b0;
`endif

endmodule
